// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared pong ball state encoding and VGA active-area geometry
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_WAIT,
    MOVE,
    SCORED
  } ball_state_t;

  // Active area in timing-generator counter space
  localparam int H_MIN = 144;
  localparam int H_MAX = 783;
  localparam int V_MIN = 35;
  localparam int V_MAX = 514;

endpackage

// File: rtl/circle_pixel.sv
// rtl/circle_pixel.sv - registered filled-circle hit test for the current pixel
module circle_pixel (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  h_counter,
  input  logic [9:0]  v_counter,
  input  logic [10:0] cx,
  input  logic [10:0] cy,
  input  logic [10:0] radius,
  input  logic        enable,
  output logic        pixel_on
);

  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic signed [23:0] dx2;
  logic signed [23:0] dy2;
  logic [23:0]        dist2;
  logic [23:0]        r2;
  logic               pixel_on_d;
  logic               pixel_on_q;

  always_comb begin
    dx         = $signed({2'b00, h_counter}) - $signed({1'b0, cx});
    dy         = $signed({2'b00, v_counter}) - $signed({1'b0, cy});
    dx2        = dx * dx;
    dy2        = dy * dy;
    dist2      = dx2 + dy2;
    r2         = {13'd0, radius} * {13'd0, radius};
    pixel_on_d = enable && (dist2 <= r2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_on_q <= 1'b0;
    end else begin
      pixel_on_q <= pixel_on_d;
    end
  end

  assign pixel_on = pixel_on_q;

endmodule

// File: rtl/ball_engine.sv
// rtl/ball_engine.sv - pong ball: serve/score FSM, per-frame motion with bounce, hit and goal,
// and registered circle rendering.
module ball_engine #(
  parameter int          H_MIN       = pong_pkg::H_MIN,
  parameter int          H_MAX       = pong_pkg::H_MAX,
  parameter int          V_MIN       = pong_pkg::V_MIN,
  parameter int          V_MAX       = pong_pkg::V_MAX,
  parameter int          RADIUS      = 6,
  parameter int          SPEED       = 4,
  parameter int          SERVE_DELAY = 60,
  parameter int          GOAL_HOLD   = 30,
  parameter logic [23:0] BALL_RGB    = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  h_counter,
  input  logic [9:0]  v_counter,
  input  logic        frame_tick,
  input  logic        serve,
  input  logic        hit_left,
  input  logic        hit_right,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        ball_on,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic        goal_left,
  output logic        goal_right
);

  typedef logic signed [11:0] s12_t;

  localparam s12_t        HMIN_S  = s12_t'(H_MIN);
  localparam s12_t        HMAX_S  = s12_t'(H_MAX);
  localparam s12_t        VMIN_S  = s12_t'(V_MIN);
  localparam s12_t        VMAX_S  = s12_t'(V_MAX);
  localparam s12_t        RAD_S   = s12_t'(RADIUS);
  localparam s12_t        SPD_S   = s12_t'(SPEED);
  localparam logic [10:0] X_CTR   = 11'((H_MIN + H_MAX) / 2);
  localparam logic [10:0] Y_CTR   = 11'((V_MIN + V_MAX) / 2);
  localparam logic [10:0] Y_TOP   = 11'(V_MIN + RADIUS);
  localparam logic [10:0] Y_BOT   = 11'(V_MAX - RADIUS);
  localparam logic [9:0]  HMIN_C  = 10'(H_MIN);
  localparam logic [9:0]  HMAX_C  = 10'(H_MAX);
  localparam logic [9:0]  VMIN_C  = 10'(V_MIN);
  localparam logic [9:0]  VMAX_C  = 10'(V_MAX);
  localparam logic [7:0]  SERVE_N = 8'(SERVE_DELAY);
  localparam logic [7:0]  GOAL_N  = 8'(GOAL_HOLD);

  pong_pkg::ball_state_t state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic        vx_q, vx_d, vy_q, vy_d, dir_q, dir_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        hit_l_q, hit_l_d, hit_r_q, hit_r_d;
  logic        goal_l_q, goal_l_d, goal_r_q, goal_r_d;
  logic        vx_eff;
  s12_t        xn, yn;
  logic        in_active;
  logic        render_en;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    goal_l_d = 1'b0;
    goal_r_d = 1'b0;
    // A hit arriving with the tick itself still counts for that tick
    hit_l_d  = hit_l_q | hit_left;
    hit_r_d  = hit_r_q | hit_right;

    vx_eff = vx_q;
    if (hit_l_d && !vx_q) begin
      vx_eff = 1'b1;
    end else if (hit_r_d && vx_q) begin
      vx_eff = 1'b0;
    end
    xn = vx_eff ? $signed({1'b0, x_q}) + SPD_S : $signed({1'b0, x_q}) - SPD_S;
    yn = vy_q   ? $signed({1'b0, y_q}) + SPD_S : $signed({1'b0, y_q}) - SPD_S;

    case (state_q)
      pong_pkg::IDLE: begin
        if (serve) begin
          state_d = pong_pkg::SERVE_WAIT;
          vx_d    = dir_q;
          vy_d    = 1'b1;
          cnt_d   = 8'd0;
        end
      end
      pong_pkg::SERVE_WAIT: begin
        if (frame_tick) begin
          if (cnt_q == SERVE_N - 8'd1) begin
            state_d = pong_pkg::MOVE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      pong_pkg::MOVE: begin
        if (frame_tick) begin
          vx_d = vx_eff;
          if (yn - RAD_S < VMIN_S) begin
            y_d  = Y_TOP;
            vy_d = 1'b1;
          end else if (yn + RAD_S > VMAX_S) begin
            y_d  = Y_BOT;
            vy_d = 1'b0;
          end else begin
            y_d = yn[10:0];
          end
          // X is judged independently so a corner yields both a bounce and a goal
          if (xn - RAD_S < HMIN_S) begin
            goal_r_d = 1'b1;
            state_d  = pong_pkg::SCORED;
            dir_d    = 1'b0;
            cnt_d    = 8'd0;
          end else if (xn + RAD_S > HMAX_S) begin
            goal_l_d = 1'b1;
            state_d  = pong_pkg::SCORED;
            dir_d    = 1'b1;
            cnt_d    = 8'd0;
          end else begin
            x_d = xn[10:0];
          end
        end
      end
      pong_pkg::SCORED: begin
        if (frame_tick) begin
          if (cnt_q == GOAL_N - 8'd1) begin
            state_d = pong_pkg::IDLE;
            x_d     = X_CTR;
            y_d     = Y_CTR;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = pong_pkg::IDLE;
    endcase

    if (frame_tick) begin
      hit_l_d = 1'b0;
      hit_r_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= pong_pkg::IDLE;
      x_q      <= X_CTR;
      y_q      <= Y_CTR;
      vx_q     <= 1'b1;
      vy_q     <= 1'b1;
      dir_q    <= 1'b1;
      cnt_q    <= 8'd0;
      hit_l_q  <= 1'b0;
      hit_r_q  <= 1'b0;
      goal_l_q <= 1'b0;
      goal_r_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      hit_l_q  <= hit_l_d;
      hit_r_q  <= hit_r_d;
      goal_l_q <= goal_l_d;
      goal_r_q <= goal_r_d;
    end
  end

  assign in_active = (h_counter >= HMIN_C) && (h_counter <= HMAX_C) &&
                     (v_counter >= VMIN_C) && (v_counter <= VMAX_C);
  assign render_en = in_active && (state_q != pong_pkg::SCORED);

  circle_pixel u_circle (
    .clk       (clk),
    .reset     (reset),
    .h_counter (h_counter),
    .v_counter (v_counter),
    .cx        (x_q),
    .cy        (y_q),
    .radius    (11'(RADIUS)),
    .enable    (render_en),
    .pixel_on  (ball_on)
  );

  assign R          = ball_on ? BALL_RGB[23:16] : 8'd0;
  assign G          = ball_on ? BALL_RGB[15:8]  : 8'd0;
  assign B          = ball_on ? BALL_RGB[7:0]   : 8'd0;
  assign ball_x     = x_q;
  assign ball_y     = y_q;
  assign goal_left  = goal_l_q;
  assign goal_right = goal_r_q;

endmodule

// File: doc/ball_engine.md
Name: ball_engine

Overview:
- Clocked, parametrised successor to the combinational ball renderer for the VGA pong game.
- Owns ball state: position, velocity, serve/score state machine. Updates position once per frame with wall bounce, paddle-hit reflection and goal detection.
- Renders a filled circle with registered RGB output for the pixel mixer.
- Sits between the VGA timing generator (counters, frame_tick) and the paddle/score logic.

Parameters:
- H_MIN, 144, first active pixel column (counter space); columns below it are blanking.
- H_MAX, 783, last active column.
- V_MIN, 35, first active line.
- V_MAX, 514, last active line.
- RADIUS, 6, ball radius in pixels; in-circle test is dist2 <= RADIUS*RADIUS.
- SPEED, 4, pixels moved per axis per frame.
- SERVE_DELAY, 60, frames between serve request and motion start.
- GOAL_HOLD, 30, frames the ball stays hidden after a goal.
- BALL_RGB, 24'hFFFFFF, ball colour {R,G,B}.

Ports:
- clk  in  1  pixel clock
- reset  in  1  reset, synchronous, active-high
- h_counter  in  10  horizontal pixel counter
- v_counter  in  10  vertical line counter
- frame_tick  in  1  one-cycle pulse per frame, issued in vertical blanking
- serve  in  1  one-cycle serve request
- hit_left  in  1  left paddle contact pulse (any cycle)
- hit_right  in  1  right paddle contact pulse
- R, G, B  out  8 each  pixel colour
- ball_on  out  1  current pixel is inside the ball
- ball_x  out  11  ball centre column
- ball_y  out  11  ball centre line
- goal_left  out  1  one-cycle pulse: ball left the field on the right (left player scores)
- goal_right  out  1  one-cycle pulse: ball left the field on the left

Behaviour:
- Reset, next edge:
  - state=IDLE; ball_x=(H_MIN+H_MAX)/2=463; ball_y=(V_MIN+V_MAX)/2=274; vx=+, vy=+.
  - serve_dir=+; frame counter 0; hit latches clear.
  - R/G/B=0; ball_on=0; goal pulses 0.
  - Reset mid-motion takes effect the same way.
- States:
  - IDLE: ball centred, still, visible. serve -> SERVE_WAIT with vx=serve_dir, vy=+, counter=0.
  - SERVE_WAIT: counter += 1 per frame_tick. At SERVE_DELAY ticks -> MOVE.
  - MOVE: update on each frame_tick as below.
  - SCORED: ball hidden. After GOAL_HOLD ticks -> IDLE, re-centred.
  - serve in any state other than IDLE is ignored.
- Hit latches: hit_left/hit_right set sticky latches, cleared on every frame_tick. A hit in the same cycle as frame_tick is counted for that tick.
- MOVE update per frame_tick, using signed 12-bit intermediates:
  - If hit_left latched and vx=-, set vx=+. If hit_right latched and vx=+, set vx=-.
  - xn = x ± SPEED, yn = y ± SPEED.
  - If yn-RADIUS < V_MIN: y=V_MIN+RADIUS, vy=+.
  - Else if yn+RADIUS > V_MAX: y=V_MAX-RADIUS, vy=-.
  - Else y=yn.
  - If xn-RADIUS < H_MIN: pulse goal_right, go to SCORED, serve_dir=-.
  - Else if xn+RADIUS > H_MAX: pulse goal_left, go to SCORED, serve_dir=+.
  - Else x=xn.
  - X and Y checks are independent, so a corner gives both a Y bounce and a goal.
- Position registers change only on frame_tick, so there is no tearing within a frame.
- Render pipeline:
  - dx=h-x, dy=v-y, signed 12-bit; dist2=dx*dx+dy*dy, unsigned 24-bit.
  - Output registered: 1-cycle latency from counters to R/G/B/ball_on.
  - ball_on=1 iff dist2<=RADIUS², pixel is inside H_MIN..H_MAX and V_MIN..V_MAX, and state != SCORED.
  - RGB=BALL_RGB when ball_on, else 0.
  - Blanking pixels are always 0.
- goal pulses: exactly 1 cycle wide, asserted in the cycle after the triggering frame_tick.

Decomposition:
- Shared package pong_pkg holds:
  - the state enum (IDLE, SERVE_WAIT, MOVE, SCORED);
  - the VGA geometry constants (H_MIN/H_MAX/V_MIN/V_MAX), also used by the paddle and score blocks.
- Natural sub-module: circle_pixel. It takes the counters, centre and radius, and produces registered ball_on. The paddle renderer can reuse it.

Test Plan:
- Reset, then sample pixel (463,274) -> ball_on=1, RGB=FFFFFF. Pixel (470,274) (dist2=49>36) -> ball_on=0. Pixel (50,274) -> RGB=0.
- serve, then 59 frame_ticks -> ball_x stays 463. 60th tick -> MOVE. 61st tick -> ball_x=467, ball_y=278.
- In MOVE with y=42, vy=- -> after the tick y=41, vy=+. Next tick -> y=45.
- vx=-, x=152, hit_left pulsed mid-frame -> next tick x=156, vx=+, no goal. Same setup without hit -> goal_right pulse 1 cycle, ball hidden. After 30 ticks -> IDLE at (463,274), next serve moves -x.
- serve pulsed during MOVE -> no state change. reset asserted during MOVE -> next cycle IDLE, centred, RGB=0 on that edge.
- Latency check: counters step to the ball edge -> ball_on changes exactly 1 clock later.
